m_imem_loader: RTL and testbench

M_IMEM_LOADER -- requirements
Module: m_imem_loader

---
 rtl/m_imem_loader_pkg.sv | 25 ++
 rtl/m_imem_loader_if.sv | 22 ++
 rtl/m_imem_loader_word_asm.sv | 35 +++
 rtl/m_imem_loader.sv | 125 ++++++++++++
 tb/tb_m_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_imem_loader_pkg.sv
// Shared state encoding and length-field width for the instruction-memory loader.
// Optional checksum state is present only when M_IMEM_LOADER_CSUM_EN is defined.
package m_imem_loader_pkg;

  localparam int LEN_W   = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef M_IMEM_LOADER_CSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Word index to byte address; low two bits are always zero.
  function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] idx);
    return {{(30-LEN_W){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/m_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = byte source / memory side, slave = loader.
interface m_imem_loader_if;

  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_rx_ready;
  logic        w_we;
  logic [31:0] w_waddr;
  logic [31:0] w_wdata;

  modport master (
    output w_rx_valid, w_rx_data,
    input  w_rx_ready, w_we, w_waddr, w_wdata
  );

  modport slave (
    input  w_rx_valid, w_rx_data,
    output w_rx_ready, w_we, w_waddr, w_wdata
  );

endinterface

// File: rtl/m_imem_loader_word_asm.sv
// Little-endian word assembler: shifts bytes in from the top, first byte ends in [7:0].
// full is high for one cycle after the 4th byte, while the complete word sits in the register.
module m_word_asm (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic        last,
  output logic        full
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  logic        full_q;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_q  <= 2'd0;
      sr_q   <= 32'd0;
      full_q <= 1'b0;
    end else begin
      full_q <= byte_vld && (cnt_q == 2'd3);
      if (byte_vld) begin
        sr_q  <= {byte_dat, sr_q[31:8]};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  assign word = sr_q;
  assign last = (cnt_q == 2'd3);
  assign full = full_q;

endmodule

// File: rtl/m_imem_loader.sv
// Boot loader: LEN_LO, LEN_HI, then 4N little-endian payload bytes written as N words from address 0.
// Write fires the cycle after each 4th byte, when w_rx_ready is low; M_IMEM_LOADER_CSUM_EN adds an XOR checksum byte.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 1024
) (
  input  logic             w_clk,
  input  logic             w_rst,
  m_imem_loader_if.slave   bus,
  output logic             w_busy,
  output logic             w_done,
  output logic             w_err
);

  localparam logic [31:0] MAX_WORDS = 32'(IMEM_WORDS);
`ifdef M_IMEM_LOADER_CSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state_q, state_nxt;
  logic              rx_ready;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  idx_nxt;
  logic [31:0]       waddr_q;
  logic [31:0]       wdata_q;
  logic              asm_vld;
  logic              asm_last;
  logic              asm_full;
  logic [31:0]       asm_word;
`ifdef M_IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  assign len_in  = {bus.w_rx_data, len_q[7:0]};
  assign idx_nxt = idx_q + LEN_W'(1);
  assign asm_vld = (state_q == S_DATA) && bus.w_rx_valid;

  m_word_asm u_word_asm (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .byte_vld (asm_vld),
    .byte_dat (bus.w_rx_data),
    .word     (asm_word),
    .last     (asm_last),
    .full     (asm_full)
  );

  // Every state that takes a byte has rx_ready high, so w_rx_valid alone means "accepted" there.
  always_comb begin
    state_nxt = state_q;
    rx_ready  = 1'b0;
    unique case (state_q)
      S_LEN0: begin
        rx_ready = 1'b1;
        if (bus.w_rx_valid) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        rx_ready = 1'b1;
        if (bus.w_rx_valid) begin
          if (len_in == '0)
            state_nxt = S_TAIL;
          else if ({{(32-LEN_W){1'b0}}, len_in} > MAX_WORDS)
            state_nxt = S_ERR;
          else
            state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (asm_vld && asm_last) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = (idx_nxt == len_q) ? S_TAIL : S_DATA;
      end
`ifdef M_IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (bus.w_rx_valid) state_nxt = (bus.w_rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: begin
        state_nxt = state_q;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      idx_q   <= '0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
`ifdef M_IMEM_LOADER_CSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_nxt;
      if ((state_q == S_LEN0) && bus.w_rx_valid) len_q[7:0] <= bus.w_rx_data;
      if ((state_q == S_LEN1) && bus.w_rx_valid) len_q      <= len_in;
      if (asm_vld && asm_last)                   waddr_q    <= word_addr(idx_q);
      if (asm_full)                              wdata_q    <= asm_word;
      if (state_q == S_WRITE)                    idx_q      <= idx_nxt;
`ifdef M_IMEM_LOADER_CSUM_EN
      if (asm_vld)                               csum_q     <= csum_q ^ bus.w_rx_data;
`endif
    end
  end

  // During the write cycle the word is read straight from the assembler; afterwards the held copy.
  assign bus.w_rx_ready = rx_ready;
  assign bus.w_we       = (state_q == S_WRITE);
  assign bus.w_waddr    = waddr_q;
  assign bus.w_wdata    = asm_full ? asm_word : wdata_q;

  assign w_done = (state_q == S_DONE);
  assign w_err  = (state_q == S_ERR);
  assign w_busy = !(w_done || w_err);

endmodule

// File: tb/tb_m_imem_loader.sv
// Randomized bench for m_imem_loader with a byte-stream reference model checked every cycle.
module tb_m_imem_loader;

  localparam int IMEM = 1024;
`ifdef M_IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  logic w_busy, w_done, w_err;

  m_imem_loader_if bus();

  m_imem_loader #(.IMEM_WORDS(IMEM)) dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .bus    (bus),
    .w_busy (w_busy),
    .w_done (w_done),
    .w_err  (w_err)
  );

  initial forever #5 w_clk = ~w_clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks position in the byte stream, not the loader's internal states.
  bit          m_ok = 1'b0;
  int          m_nb, m_len, m_words, m_k;
  bit          m_wr_pend, m_done, m_err, m_csum_phase;
  logic [31:0] m_cur, m_waddr, m_wdata;
  logic [7:0]  m_xor, m_b;

  always @(posedge w_clk) begin
    if (w_rst) begin
      m_ok = 1'b1; m_nb = 0; m_len = 0; m_words = 0;
      m_wr_pend = 1'b0; m_done = 1'b0; m_err = 1'b0; m_csum_phase = 1'b0;
      m_cur = 32'd0; m_waddr = 32'd0; m_wdata = 32'd0; m_xor = 8'd0;
    end else if (m_ok) begin
      if (m_wr_pend) begin
        m_wr_pend = 1'b0;
        m_words++;
        if (m_words == m_len) begin
          if (CSUM) m_csum_phase = 1'b1; else m_done = 1'b1;
        end
      end else if (bus.w_rx_valid && !(m_done || m_err)) begin
        m_b = bus.w_rx_data;
        if (m_csum_phase) begin
          if (m_b == m_xor) m_done = 1'b1; else m_err = 1'b1;
        end else if (m_nb == 0) begin
          m_len = int'(m_b);
        end else if (m_nb == 1) begin
          m_len = m_len + int'(m_b) * 256;
          if (m_len == 0) begin
            if (CSUM) m_csum_phase = 1'b1; else m_done = 1'b1;
          end else if (m_len > IMEM) begin
            m_err = 1'b1;
          end
        end else begin
          m_k = m_nb - 2;
          m_cur[8*(m_k%4) +: 8] = m_b;
          m_xor = m_xor ^ m_b;
          if (m_k % 4 == 3) begin
            m_wr_pend = 1'b1;
            m_waddr   = 32'((m_k / 4) * 4);
            m_wdata   = m_cur;
          end
        end
        m_nb++;
      end
    end
  end

  logic [63:0] wr_log[$];

  always @(negedge w_clk) begin
    if (bus.w_we === 1'b1) wr_log.push_back({bus.w_waddr, bus.w_wdata});
    if (m_ok) begin
      check("rx_ready", 32'(bus.w_rx_ready), 32'(!(m_done || m_err || m_wr_pend)));
      check("we",       32'(bus.w_we),       32'(m_wr_pend));
      check("waddr",    bus.w_waddr,         m_waddr);
      check("wdata",    bus.w_wdata,         m_wdata);
      check("busy",     32'(w_busy),         32'(!(m_done || m_err)));
      check("done",     32'(w_done),         32'(m_done));
      check("err",      32'(w_err),          32'(m_err));
    end
  end

  logic [7:0] stim[$];

  task automatic add_len(input int n);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
  endtask

  task automatic add_csum(input bit good);
    logic [7:0] x;
    x = 8'd0;
    if (CSUM) begin
      for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
      stim.push_back(good ? x : (x ^ 8'h01));
    end
  endtask

  task automatic drive_idle_cycle();
    bus.w_rx_valid = bus.w_rx_ready ? 1'b0 : 1'($urandom_range(1));
    bus.w_rx_data  = 8'($urandom);
  endtask

  // Presents each byte only when the loader is ready; while it is not, junk bytes are strobed to be dropped.
  task automatic send_stream(input int gap_pct);
    bit sent;
    for (int i = 0; i < stim.size(); i++) begin
      sent = 1'b0;
      for (int t = 0; t < 64 && !sent; t++) begin
        @(negedge w_clk);
        if (bus.w_rx_ready && ($urandom_range(99) >= gap_pct)) begin
          bus.w_rx_valid = 1'b1;
          bus.w_rx_data  = stim[i];
          sent = 1'b1;
        end else begin
          drive_idle_cycle();
        end
      end
      if (!sent) begin
        n_vec++;
        n_fail++;
        $display("FAIL send_timeout: byte %0d of %0d never accepted", i, stim.size());
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge w_clk);
      drive_idle_cycle();
    end
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst = 1'b1;
    bus.w_rx_valid = 1'b0;
    @(negedge w_clk);
    w_rst = 1'b0;
    wr_log.delete();
    stim.delete();
  endtask

  int  n;
  bit  good, exp_ok;

  initial begin
    bus.w_rx_valid = 1'b0;
    bus.w_rx_data  = 8'd0;
    repeat (2) @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.w_rx_ready), 32'd1);
    check("rst_busy",  32'(w_busy),         32'd1);
    check("rst_done",  32'(w_done),         32'd0);
    check("rst_err",   32'(w_err),          32'd0);
    check("rst_we",    32'(bus.w_we),       32'd0);
    check("rst_wdata", bus.w_wdata,         32'd0);

    // Single word image.
    do_reset();
    stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'h13); stim.push_back(8'h05); stim.push_back(8'hA0); stim.push_back(8'h00);
    add_csum(1'b1);
    send_stream(0);
    idle(4);
    check("one_nwr",   32'(wr_log.size()), 32'd1);
    check("one_waddr", wr_log[0][63:32],   32'h0000_0000);
    check("one_wdata", wr_log[0][31:0],    32'h00A0_0513);
    check("one_done",  32'(w_done),        32'd1);
    check("one_busy",  32'(w_busy),        32'd0);

    // Two words with valid gaps.
    do_reset();
    add_len(2); add_word(32'h4433_2211); add_word(32'h8877_6655);
    add_csum(1'b1);
    send_stream(50);
    idle(4);
    check("two_nwr",    32'(wr_log.size()), 32'd2);
    check("two_addr0",  wr_log[0][63:32],   32'h0000_0000);
    check("two_data0",  wr_log[0][31:0],    32'h4433_2211);
    check("two_addr1",  wr_log[1][63:32],   32'h0000_0004);
    check("two_data1",  wr_log[1][31:0],    32'h8877_6655);
    check("two_done",   32'(w_done),        32'd1);

    // Length one past capacity.
    do_reset();
    stim.push_back(8'h01); stim.push_back(8'h04);
    send_stream(0);
    idle(6);
    check("big_err", 32'(w_err),          32'd1);
    check("big_nwr", 32'(wr_log.size()), 32'd0);

    // Empty image.
    do_reset();
    add_len(0); add_csum(1'b1);
    send_stream(0);
    idle(3);
    check("empty_done", 32'(w_done),        32'd1);
    check("empty_nwr",  32'(wr_log.size()), 32'd0);

`ifdef M_IMEM_LOADER_CSUM_EN
    do_reset();
    add_len(1); add_word(32'h1122_3344); stim.push_back(8'h44);
    send_stream(20);
    idle(3);
    check("csum_ok_done", 32'(w_done), 32'd1);
    do_reset();
    add_len(1); add_word(32'h1122_3344); stim.push_back(8'h45);
    send_stream(20);
    idle(3);
    check("csum_bad_err", 32'(w_err),          32'd1);
    check("csum_bad_nwr", 32'(wr_log.size()), 32'd1);
`endif

    // Reset after two payload bytes, then a full image.
    do_reset();
    stim.push_back(8'h01); stim.push_back(8'h00); stim.push_back(8'hAA); stim.push_back(8'hBB);
    send_stream(0);
    do_reset();
    add_len(1); add_word(32'hDEAD_BEEF); add_csum(1'b1);
    send_stream(30);
    idle(4);
    check("abort_nwr",   32'(wr_log.size()), 32'd1);
    check("abort_waddr", wr_log[0][63:32],   32'h0000_0000);
    check("abort_wdata", wr_log[0][31:0],    32'hDEAD_BEEF);
    check("abort_done",  32'(w_done),        32'd1);

    // Reset asserted during the write cycle.
    do_reset();
    add_len(3); add_word(32'hCAFE_F00D);
    send_stream(0);
    @(negedge w_clk);
    #1;
    check("wrst_we1",   32'(bus.w_we),  32'd1);
    check("wrst_wdata", bus.w_wdata,    32'hCAFE_F00D);
    w_rst = 1'b1;
    bus.w_rx_valid = 1'b0;
    @(negedge w_clk);
    #1;
    check("wrst_we0",    32'(bus.w_we),       32'd0);
    check("wrst_ready",  32'(bus.w_rx_ready), 32'd1);
    w_rst = 1'b0;

    // Exactly full memory.
    do_reset();
    add_len(IMEM);
    for (int i = 0; i < IMEM; i++) add_word($urandom);
    add_csum(1'b1);
    send_stream(0);
    idle(4);
    check("full_nwr",  32'(wr_log.size()),              32'd1024);
    check("full_last", wr_log[wr_log.size()-1][63:32], 32'h0000_0FFC);
    check("full_done", 32'(w_done),                     32'd1);

    // Random images.
    for (int it = 0; it < 24; it++) begin
      do_reset();
      n    = ($urandom_range(7) == 0) ? IMEM + 1 + $urandom_range(300) : $urandom_range(5);
      good = ($urandom_range(3) != 0);
      add_len(n);
      if (n <= IMEM) begin
        for (int i = 0; i < n; i++) add_word($urandom);
        add_csum(good);
      end
      send_stream($urandom_range(60));
      idle(6);
      exp_ok = (n <= IMEM) && (good || !CSUM);
      check("rnd_done", 32'(w_done),        32'(exp_ok));
      check("rnd_err",  32'(w_err),         32'(!exp_ok));
      check("rnd_nwr",  32'(wr_log.size()), (n <= IMEM) ? 32'(n) : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
